alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal values 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): derived shift-amount width; not overridden by users.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  4  operation select, alu_op_e from the package.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; shifts use b[SHAMT_W-1:0] only.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flag_zero, flag_carry, flag_ovf  output  1 each  registered flags accompanying result.
REQ-014 busy  output  1  high while a multi-cycle multiply is in progress.

Function
REQ-015 Acceptance SHALL occur on an edge where in_valid && in_ready; op/a/b are sampled only then.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-017 Ops: ADD a+b; SUB a-b; NOT ~a; SLL a<<sh; SRL a>>sh logical; SRA a>>>sh arithmetic; AND; OR; XOR; SLT signed a<b -> 1 else 0; SLTU unsigned a<b -> 1 else 0; MUL low WIDTH bits of a*b, unsigned.
REQ-018 Unassigned op codes SHALL behave as ADD.
REQ-019 Non-MUL ops: result, flags, out_valid SHALL be written on the accepting edge (latency 1 cycle).
REQ-020 MUL: accepting edge moves FSM IDLE->MUL and loads multiplicand, multiplier, accumulator=0, count=0.
REQ-021 In MUL, each cycle: if multiplier LSB set, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
REQ-022 On the edge where count reaches WIDTH-1 the final sum SHALL be written to result, out_valid set, FSM->IDLE; out_valid visible exactly WIDTH cycles after acceptance.
REQ-023 busy SHALL be 1 exactly while state==MUL; in_ready is 0 throughout.
REQ-024 out_valid SHALL clear on an edge where out_valid && out_ready, unless a new non-MUL result is written on the same edge, in which case it stays 1 with the new data.
REQ-025 result and flags SHALL remain stable while out_valid && !out_ready.
REQ-026 flag_zero = (result==0) for all ops.
REQ-027 flag_carry: ADD carry-out; SUB borrow (a<b unsigned); 0 for all other ops.
REQ-028 flag_ovf: ADD/SUB signed overflow; 0 for all other ops.
REQ-029 Shift amounts >= WIDTH are impossible by construction (SHAMT_W bits); sh=0 returns a unchanged.

Reset
REQ-030 While rst is high on an edge: state=IDLE, out_valid=0, result=0, all flags=0, busy=0, internal multiply registers=0.
REQ-031 Reset during MUL SHALL abort it; no result is ever emitted for that request.
REQ-032 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold alu_op_e (4-bit enum: ADD, SUB, NOT, SLL, SRL, SRA, AND, OR, XOR, SLT, SLTU, MUL) and alu_state_e (IDLE, MUL).
REQ-034 Iterative shift-add multiplier SHALL be a sub-module alu_mul_iter (start, operands in; done, product out), instantiated once.
REQ-035 Single-cycle datapath and flag logic SHALL be combinational feeding the output register.

Verification (WIDTH=32)
REQ-036 ADD a=0xFFFFFFFF b=1 -> next cycle out_valid=1, result=0, zero=1, carry=1, ovf=0.
REQ-037 SUB a=0x80000000 b=1 -> result=0x7FFFFFFF, ovf=1, carry=0, zero=0.
REQ-038 MUL a=0x00010003 b=5 -> result=0x0005000F, out_valid exactly 32 cycles after accept, in_ready=0 and busy=1 in between.
REQ-039 out_ready=0, ADD 2+3 then in_valid held with SUB -> in_ready=0, result 5 stable; raise out_ready -> SUB accepted same cycle, its result next cycle.
REQ-040 rst pulsed at cycle 10 of MUL -> next cycle busy=0, out_valid=0, in_ready=1; no result observed afterward.
REQ-041 SRA 0x80000000 by 4 -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // 4-bit operation select; codes 12..15 are unassigned and decode as ADD.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOT  = 4'd2,
        OP_SLL  = 4'd3,
        OP_SRL  = 4'd4,
        OP_SRA  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    // Controller state: idle (accepting) or running the iterative multiply.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between an ALU client (master) and alu_seq (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the result side.
// Ports: in_valid/in_ready/op/a/b request; out_valid/out_ready/result/flags
//        result; busy status.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b (unsigned).
// Latency: WIDTH cycles from start to the done edge (one multiplier bit per cycle).
// Backpressure: none; the caller must hold off new work until done.
// Ports: clk/rst; start with a/b operands in; done pulse with product out.
module alu_mul_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic               active;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] count;
    logic               last;

    assign last = (count == SHAMT_W'(WIDTH - 1));

    // Accumulator including this cycle's partial product, so the final bit's
    // contribution is available on the same edge that reports done.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = active && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            active <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + SHAMT_W'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus iterative MUL.
// Latency: 1 cycle for non-MUL ops; WIDTH cycles for MUL.
// Backpressure: in_ready drops while multiplying or while a result waits on out_ready.
// Ports: clk/rst scalars; bus (alu_seq_if.slave) carries request, result, flags, busy.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    import alu_pkg::*;

    alu_state_e         state;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_product;
    logic [SHAMT_W-1:0] sh;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH-1:0]   comb_result;
    logic               comb_carry;
    logic               comb_ovf;

    assign bus.in_ready = (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
    assign bus.busy     = (state == ST_MUL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_mul       = (bus.op == OP_MUL);
    assign sh           = bus.b[SHAMT_W-1:0];

    assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign sub_ext = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        comb_result = add_ext[WIDTH-1:0];
        comb_carry  = 1'b0;
        comb_ovf    = 1'b0;
        case (bus.op)
            OP_SUB: begin
                comb_result = sub_ext[WIDTH-1:0];
                comb_carry  = sub_ext[WIDTH];
                comb_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOT:  comb_result = ~bus.a;
            OP_SLL:  comb_result = bus.a << sh;
            OP_SRL:  comb_result = bus.a >> sh;
            OP_SRA:  comb_result = $signed(bus.a) >>> sh;
            OP_AND:  comb_result = bus.a & bus.b;
            OP_OR:   comb_result = bus.a | bus.b;
            OP_XOR:  comb_result = bus.a ^ bus.b;
            OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: begin
                // ADD and every unassigned code; MUL never reaches the output from here.
                comb_result = add_ext[WIDTH-1:0];
                comb_carry  = add_ext[WIDTH];
                comb_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
        endcase
    end

    alu_mul_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.out_valid  <= 1'b0;
            bus.result     <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_carry <= 1'b0;
            bus.flag_ovf   <= 1'b0;
        end else if (accept && is_mul) begin
            // Acceptance implies any pending result is consumed on this edge.
            state         <= ST_MUL;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.result     <= comb_result;
            bus.flag_zero  <= (comb_result == '0);
            bus.flag_carry <= comb_carry;
            bus.flag_ovf   <= comb_ovf;
        end else if (mul_done) begin
            state          <= ST_IDLE;
            bus.out_valid  <= 1'b1;
            bus.result     <= mul_product;
            bus.flag_zero  <= (mul_product == '0);
            bus.flag_carry <= 1'b0;
            bus.flag_ovf   <= 1'b0;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
// Latency: checks 1-cycle ops and the WIDTH-cycle multiply timing.
// Backpressure: exercises held requests while out_ready is low.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic seen_valid;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (caller ensures in_ready).
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.op       = alu_op_e'(op);
        bus.a        = a;
        bus.b        = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        seen_valid    = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", bus.in_ready, 1);

        // ADD wraps to zero with carry out.
        issue(4'd0, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap_valid", bus.out_valid, 1);
        check("add_wrap_result", bus.result, 32'h0);
        check("add_wrap_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b110);

        // SUB signed overflow from most-negative value.
        issue(4'd1, 32'h8000_0000, 32'h1);
        check("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
        check("sub_ovf_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b001);

        issue(4'd1, 32'h1, 32'h2);
        check("sub_borrow_result", bus.result, 32'hFFFF_FFFF);
        check("sub_borrow_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b010);

        issue(4'd0, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_result", bus.result, 32'h8000_0000);
        check("add_ovf_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b001);

        issue(4'd5, 32'h8000_0000, 32'd4);
        check("sra", bus.result, 32'hF800_0000);
        issue(4'd9, 32'hFFFF_FFFF, 32'h1);
        check("slt", bus.result, 32'h1);
        issue(4'd10, 32'hFFFF_FFFF, 32'h1);
        check("sltu", bus.result, 32'h0);
        check("sltu_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b100);

        issue(4'd3, 32'h1, 32'd31);
        check("sll_31", bus.result, 32'h8000_0000);
        issue(4'd3, 32'h1, 32'h25);
        check("sll_uses_low_bits", bus.result, 32'h20);
        issue(4'd4, 32'h8000_0000, 32'd31);
        check("srl_31", bus.result, 32'h1);
        issue(4'd4, 32'h1234_5678, 32'd0);
        check("srl_zero_shift", bus.result, 32'h1234_5678);
        issue(4'd2, 32'h0, 32'h0);
        check("not", bus.result, 32'hFFFF_FFFF);
        issue(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and", bus.result, 32'hF000_F000);
        issue(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or", bus.result, 32'hFFF0_FFF0);
        issue(4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("xor", bus.result, 32'h0FF0_0FF0);
        issue(4'd13, 32'd2, 32'd3);
        check("unassigned_as_add", bus.result, 32'd5);
        step();
        check("valid_clears_on_take", bus.out_valid, 0);

        // MUL: result exactly 32 cycles after the accepting edge.
        issue(4'd11, 32'h0001_0003, 32'd5);
        check("mul_accept_state", {bus.out_valid, bus.busy, bus.in_ready}, 3'b010);
        for (int k = 1; k < W; k++) begin
            step();
            check("mul_in_progress", {bus.out_valid, bus.busy, bus.in_ready}, 3'b010);
        end
        step();
        check("mul_done_state", {bus.out_valid, bus.busy, bus.in_ready}, 3'b101);
        check("mul_result", bus.result, 32'h0005_000F);
        check("mul_zcv", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 3'b000);

        // MUL with all bits set exercises every partial product.
        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= W; k++) step();
        check("mul_full_valid", bus.out_valid, 1);
        check("mul_full_result", bus.result, 32'h1);
        step();

        // Backpressure: held result stays put, held request waits.
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd2, 32'd3);
        check("bp_first_result", bus.result, 32'd5);
        bus.in_valid = 1'b1;
        bus.op       = OP_SUB;
        bus.a        = 32'd9;
        bus.b        = 32'd2;
        #1;
        check("bp_ready_low", bus.in_ready, 0);
        step();
        step();
        check("bp_result_stable", bus.result, 32'd5);
        check("bp_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_on_release", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("bp_sub_valid", bus.out_valid, 1);
        check("bp_sub_result", bus.result, 32'd7);
        step();

        // Reset during MUL aborts it.
        issue(4'd11, 32'd3, 32'd3);
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
        check("abort_result", bus.result, 32'h0);
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("abort_no_result", seen_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
